wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 DATA_WIDTH, 64, width of write-back data.
REQ-002 ADDR_WIDTH, 5, width of register address.
REQ-003 FIFO_DEPTH, 2, number of long-latency result entries buffered (power of two, >=2).
REQ-004 in_Clk  input  1  clock, rising edge.
REQ-005 in_Rst_N  input  1  asynchronous, active-low reset.
REQ-006 in_alu_valid  input  1  single-cycle ALU result present; no backpressure.
REQ-007 in_alu_addr / in_alu_data  input  ADDR_WIDTH / DATA_WIDTH  ALU destination and result.
REQ-008 in_lsu_valid  input  1  long-latency (load/FPU-to-int) result offered.
REQ-009 out_lsu_ready  output  1  arbiter can accept the long-latency result.
REQ-010 in_lsu_addr / in_lsu_data  input  ADDR_WIDTH / DATA_WIDTH  long-latency destination and result.
REQ-011 out_wb_en / out_wb_addr / out_wb_data  output  1 / ADDR_WIDTH / DATA_WIDTH  registered write port driving the register file write enable, address and data.
REQ-012 out_fifo_count  output  $clog2(FIFO_DEPTH)+1  current buffered entries.

Function
REQ-013 The block SHALL merge two producers onto the single register-file write port, with ALU having absolute priority.
REQ-014 LSU transfer SHALL occur on a rising edge with in_lsu_valid && out_lsu_ready; out_lsu_ready = (count < FIFO_DEPTH), from registered state only.
REQ-015 When full, out_lsu_ready SHALL be 0 even if a pop occurs that cycle (no same-cycle push-on-pop at full).
REQ-016 Output selection per cycle, in priority order: ALU valid with addr!=0 -> ALU; else FIFO non-empty -> pop head; else LSU transfer with FIFO empty -> LSU directly (not pushed); else out_wb_en=0.
REQ-017 An LSU transfer not sent directly SHALL be pushed to the FIFO tail; simultaneous push and pop SHALL keep count unchanged.
REQ-018 Latency: ALU result SHALL appear on out_wb_* 1 cycle after presentation; LSU result 1 cycle after transfer when FIFO empty and ALU idle.
REQ-019 FIFO order SHALL be preserved; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 Writes addressed to register 0 SHALL be discarded: ALU treated as not valid; LSU transfer accepted (handshake completes) but never buffered or written.
REQ-021 When out_wb_en=0, out_wb_addr and out_wb_data SHALL hold their previous values.
REQ-022 WAW ordering between ALU and buffered LSU results to the same register is the issue stage's responsibility; the block SHALL NOT reorder or merge entries.

Reset
REQ-023 in_Rst_N low SHALL asynchronously clear out_wb_en, out_wb_addr, out_wb_data, pointers and count to 0; out_lsu_ready therefore reads 1.
REQ-024 Reset mid-operation SHALL drop all buffered entries; no write SHALL be issued on the first edge after deassertion unless a new valid input is present.

Configuration
REQ-025 Macro WB_FORWARD_EN SHALL, when defined, add in_rd_addr_A/in_rd_addr_B (input, ADDR_WIDTH), out_fwd_hit_A/out_fwd_hit_B (output, 1) and out_fwd_data_A/out_fwd_data_B (output, DATA_WIDTH).
REQ-026 With WB_FORWARD_EN, out_fwd_hit_X = out_wb_en && in_rd_addr_X==out_wb_addr && in_rd_addr_X!=0, and out_fwd_data_X = out_wb_data, combinational; reset values 0.
REQ-027 Without WB_FORWARD_EN, those ports and their logic SHALL not exist; all other behaviour identical.

Structure
REQ-028 DATA_WIDTH, ADDR_WIDTH and the register-0 constant SHALL come from the shared core package/header used by the register file and pipeline stages.
REQ-029 The buffer SHALL be a sub-module wb_fifo (parameterised depth/width, push/pop/count); arbitration and output register stay in wb_arbiter.

Verification
REQ-030 ALU only: alu_valid=1, addr=3, data=0xAA at edge N -> out_wb_en=1, addr=3, data=0xAA after edge N+1; lsu idle, count=0.
REQ-031 LSU direct: lsu valid, addr=7, data=0x55, ALU idle, FIFO empty -> ready=1, written after next edge, count stays 0.
REQ-032 Contention: ALU busy 4 cycles while LSU offers addr 5,6,7 -> 5,6 buffered (count=2), ready=0 for 7; after ALU stops, writes 5,6,7 appear in order on consecutive cycles.
REQ-033 Register 0: ALU addr=0 -> no write; LSU addr=0 -> handshake completes, count unchanged, out_wb_en=0.
REQ-034 Reset mid-operation: count=2, assert in_Rst_N low between edges -> outputs and count 0 immediately, ready=1, no stale write after release.
REQ-035 With WB_FORWARD_EN: out_wb_addr=4, out_wb_en=1, in_rd_addr_A=4, in_rd_addr_B=0 -> hit_A=1, data_A=out_wb_data, hit_B=0.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared core constants for the write-back path: data/address widths, the
// hard-wired zero register, and the write-back source encoding.
package wb_arbiter_pkg;

  localparam int WB_DATA_WIDTH = 64;
  localparam int WB_ADDR_WIDTH = 5;

  // Architectural register 0 is hard-wired; writes to it are dropped.
  localparam logic [WB_ADDR_WIDTH-1:0] REG_ZERO = '0;

  // Which producer drives the write port in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_FIFO = 2'd2,
    SRC_LSU  = 2'd3
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO holding long-latency write-back entries ({addr, data}) while the
// ALU owns the register-file write port. The head entry is read
// combinationally so a pop reaches the output register in the same cycle.
// Pointers wrap naturally because DEPTH is a power of two.
module wb_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 69,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             in_Clk,
  input  logic             in_Rst_N,
  input  logic             in_push,
  input  logic [WIDTH-1:0] in_push_data,
  input  logic             in_pop,
  output logic [WIDTH-1:0] out_head_data,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  // Push into a full buffer or pop from an empty one is ignored outright.
  assign push_ok = in_push && (count_q < FULL_CNT);
  assign pop_ok  = in_pop  && (count_q != '0);

  // Pointer and occupancy next-state; push+pop together leaves count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the buffer.
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset since count gates every read.
  always_ff @(posedge in_Clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= in_push_data;
  end

  assign out_head_data = mem_q[rd_ptr_q];
  assign out_count     = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the single-cycle ALU result and long-latency
// (load / FPU-to-int) results onto one registered register-file write port.
// The ALU always wins; long-latency results wait in wb_fifo and drain in order.
// Optional build macro: WB_FORWARD_EN adds two read-port bypass comparators
// against the registered write port.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter  int DATA_WIDTH = WB_DATA_WIDTH,
  parameter  int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter  int FIFO_DEPTH = 2,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  in_Clk,
  input  logic                  in_Rst_N,
  input  logic                  in_alu_valid,
  input  logic [ADDR_WIDTH-1:0] in_alu_addr,
  input  logic [DATA_WIDTH-1:0] in_alu_data,
  input  logic                  in_lsu_valid,
  output logic                  out_lsu_ready,
  input  logic [ADDR_WIDTH-1:0] in_lsu_addr,
  input  logic [DATA_WIDTH-1:0] in_lsu_data,
  output logic                  out_wb_en,
  output logic [ADDR_WIDTH-1:0] out_wb_addr,
  output logic [DATA_WIDTH-1:0] out_wb_data,
`ifdef WB_FORWARD_EN
  input  logic [ADDR_WIDTH-1:0] in_rd_addr_A,
  input  logic [ADDR_WIDTH-1:0] in_rd_addr_B,
  output logic                  out_fwd_hit_A,
  output logic                  out_fwd_hit_B,
  output logic [DATA_WIDTH-1:0] out_fwd_data_A,
  output logic [DATA_WIDTH-1:0] out_fwd_data_B,
`endif
  output logic [CNT_W-1:0]      out_fifo_count
);

  localparam int                    ENTRY_W   = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

  logic [CNT_W-1:0]      fifo_count;
  logic [ENTRY_W-1:0]    fifo_head;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  lsu_ready;
  logic                  lsu_xfer;
  logic                  lsu_live;
  logic                  alu_take;
  wb_src_e               src;

  logic                  wb_en_q,   wb_en_d;
  logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;

  // Ready depends only on registered occupancy, so a full buffer refuses
  // even in a cycle where it is also being popped.
  assign fifo_empty = (fifo_count == '0);
  assign lsu_ready  = (fifo_count < FULL_CNT);
  assign lsu_xfer   = in_lsu_valid && lsu_ready;

  // Register-0 results are dead: ALU counts as idle, LSU handshakes but is dropped.
  assign alu_take = in_alu_valid && (in_alu_addr != ZERO_ADDR);
  assign lsu_live = lsu_xfer && (in_lsu_addr != ZERO_ADDR);

  // Pick the write-back source: ALU, then oldest buffered entry, then a bypassing LSU result.
  always_comb begin
    src = SRC_NONE;
    if (alu_take) begin
      src = SRC_ALU;
    end else if (!fifo_empty) begin
      src = SRC_FIFO;
    end else if (lsu_live) begin
      src = SRC_LSU;
    end
  end

  // A live LSU result that does not go straight out joins the tail, keeping order.
  assign fifo_pop  = (src == SRC_FIFO);
  assign fifo_push = lsu_live && (src != SRC_LSU);

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_wb_fifo (
    .in_Clk        (in_Clk),
    .in_Rst_N      (in_Rst_N),
    .in_push       (fifo_push),
    .in_push_data  ({in_lsu_addr, in_lsu_data}),
    .in_pop        (fifo_pop),
    .out_head_data (fifo_head),
    .out_count     (fifo_count)
  );

  // Next write-port value; address and data hold when nothing is written.
  always_comb begin
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    unique case (src)
      SRC_ALU: begin
        wb_en_d   = 1'b1;
        wb_addr_d = in_alu_addr;
        wb_data_d = in_alu_data;
      end
      SRC_FIFO: begin
        wb_en_d                = 1'b1;
        {wb_addr_d, wb_data_d} = fifo_head;
      end
      SRC_LSU: begin
        wb_en_d   = 1'b1;
        wb_addr_d = in_lsu_addr;
        wb_data_d = in_lsu_data;
      end
      SRC_NONE: begin
        wb_en_d = 1'b0;
      end
    endcase
  end

  // Registered register-file write port.
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign out_lsu_ready  = lsu_ready;
  assign out_wb_en      = wb_en_q;
  assign out_wb_addr    = wb_addr_q;
  assign out_wb_data    = wb_data_q;
  assign out_fifo_count = fifo_count;

`ifdef WB_FORWARD_EN
  // Bypass: a read port matching the in-flight write sees its data this cycle.
  assign out_fwd_hit_A  = wb_en_q && (in_rd_addr_A == wb_addr_q) && (in_rd_addr_A != ZERO_ADDR);
  assign out_fwd_hit_B  = wb_en_q && (in_rd_addr_B == wb_addr_q) && (in_rd_addr_B != ZERO_ADDR);
  assign out_fwd_data_A = wb_data_q;
  assign out_fwd_data_B = wb_data_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a vector table walks ALU-only, LSU-direct,
// register-0, contention and FIFO-wrap cases; hand sequences cover the
// mid-operation asynchronous reset and, when WB_FORWARD_EN is defined, bypass.
module tb_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [63:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_addr;
  logic [63:0] lsu_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic [1:0]  fifo_count;
`ifdef WB_FORWARD_EN
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic        fwd_hit_a;
  logic        fwd_hit_b;
  logic [63:0] fwd_data_a;
  logic [63:0] fwd_data_b;
`endif

  int passed = 0;
  int total  = 0;

  wb_arbiter dut (
    .in_Clk         (clk),
    .in_Rst_N       (rst_n),
    .in_alu_valid   (alu_valid),
    .in_alu_addr    (alu_addr),
    .in_alu_data    (alu_data),
    .in_lsu_valid   (lsu_valid),
    .out_lsu_ready  (lsu_ready),
    .in_lsu_addr    (lsu_addr),
    .in_lsu_data    (lsu_data),
    .out_wb_en      (wb_en),
    .out_wb_addr    (wb_addr),
    .out_wb_data    (wb_data),
`ifdef WB_FORWARD_EN
    .in_rd_addr_A   (rd_addr_a),
    .in_rd_addr_B   (rd_addr_b),
    .out_fwd_hit_A  (fwd_hit_a),
    .out_fwd_hit_B  (fwd_hit_b),
    .out_fwd_data_A (fwd_data_a),
    .out_fwd_data_B (fwd_data_b),
`endif
    .out_fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        alu_v;
    logic [4:0]  alu_a;
    logic [63:0] alu_d;
    logic        lsu_v;
    logic [4:0]  lsu_a;
    logic [63:0] lsu_d;
    logic        exp_rdy;
    logic        exp_en;
    logic [4:0]  exp_a;
    logic [63:0] exp_d;
    logic [1:0]  exp_cnt;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [63:0] ad,
                              input logic lv, input logic [4:0] la, input logic [63:0] ld,
                              input logic rdy, input logic en, input logic [4:0] ea,
                              input logic [63:0] ed, input logic [1:0] ec);
    vec_t v;
    v.alu_v = av; v.alu_a = aa; v.alu_d = ad;
    v.lsu_v = lv; v.lsu_a = la; v.lsu_d = ld;
    v.exp_rdy = rdy; v.exp_en = en; v.exp_a = ea; v.exp_d = ed; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [63:0] ad,
                       input logic lv, input logic [4:0] la, input logic [63:0] ld);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    lsu_valid = lv; lsu_addr = la; lsu_data = ld;
  endtask

  initial begin
    vec_t v;

    // Columns: alu v/a/d, lsu v/a/d, ready before edge, then en/addr/data/count after edge.
    vecs[0]  = mk(1, 3, 64'hAA,  0, 0, 64'h0,   1, 1, 3, 64'hAA,  2'd0); // ALU only
    vecs[1]  = mk(0, 0, 64'h0,   0, 0, 64'h0,   1, 0, 3, 64'hAA,  2'd0); // idle holds addr/data
    vecs[2]  = mk(0, 0, 64'h0,   1, 7, 64'h55,  1, 1, 7, 64'h55,  2'd0); // LSU direct
    vecs[3]  = mk(1, 0, 64'h11,  0, 0, 64'h0,   1, 0, 7, 64'h55,  2'd0); // ALU to r0 dropped
    vecs[4]  = mk(0, 0, 64'h0,   1, 0, 64'h22,  1, 0, 7, 64'h55,  2'd0); // LSU to r0 dropped
    vecs[5]  = mk(1, 1, 64'h100, 1, 5, 64'h505, 1, 1, 1, 64'h100, 2'd1); // contention: 5 buffered
    vecs[6]  = mk(1, 2, 64'h200, 1, 6, 64'h606, 1, 1, 2, 64'h200, 2'd2); // 6 buffered, full
    vecs[7]  = mk(1, 3, 64'h300, 1, 7, 64'h707, 0, 1, 3, 64'h300, 2'd2); // 7 refused
    vecs[8]  = mk(1, 4, 64'h400, 1, 7, 64'h707, 0, 1, 4, 64'h400, 2'd2); // 7 still refused
    vecs[9]  = mk(0, 0, 64'h0,   1, 7, 64'h707, 0, 1, 5, 64'h505, 2'd1); // pop at full, no push
    vecs[10] = mk(0, 0, 64'h0,   1, 7, 64'h707, 1, 1, 6, 64'h606, 2'd1); // push 7 + pop 6
    vecs[11] = mk(0, 0, 64'h0,   0, 0, 64'h0,   1, 1, 7, 64'h707, 2'd0); // pop 7 (wrapped slot)
    vecs[12] = mk(0, 0, 64'h0,   0, 0, 64'h0,   1, 0, 7, 64'h707, 2'd0); // drained
    vecs[13] = mk(1, 8, 64'h800, 1, 9, 64'h909, 1, 1, 8, 64'h800, 2'd1); // 9 buffered
    vecs[14] = mk(1, 0, 64'hEE,  1, 0, 64'hFF,  1, 1, 9, 64'h909, 2'd0); // r0 both: pop wins
    vecs[15] = mk(0, 0, 64'h0,   0, 0, 64'h0,   1, 0, 9, 64'h909, 2'd0);

    rst_n = 1'b0;
    drive(0, 0, 64'h0, 0, 0, 64'h0);
`ifdef WB_FORWARD_EN
    rd_addr_a = '0;
    rd_addr_b = '0;
`endif
    #2;
    chk("reset_en",    64'(wb_en),      64'h0);
    chk("reset_addr",  64'(wb_addr),    64'h0);
    chk("reset_data",  wb_data,         64'h0);
    chk("reset_count", 64'(fifo_count), 64'h0);
    chk("reset_ready", 64'(lsu_ready),  64'h1);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_release_en", 64'(wb_en), 64'h0);

    for (int i = 0; i < 16; i++) begin
      v = vecs[i];
      @(negedge clk);
      drive(v.alu_v, v.alu_a, v.alu_d, v.lsu_v, v.lsu_a, v.lsu_d);
      #1;
      chk($sformatf("v%0d_ready", i), 64'(lsu_ready), 64'(v.exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_en", i),    64'(wb_en),      64'(v.exp_en));
      chk($sformatf("v%0d_addr", i),  64'(wb_addr),    64'(v.exp_a));
      chk($sformatf("v%0d_data", i),  wb_data,         v.exp_d);
      chk($sformatf("v%0d_count", i), 64'(fifo_count), 64'(v.exp_cnt));
      $display("vec %0d: wb_en=%0b wb_addr=%0d wb_data=%0h count=%0d", i, wb_en, wb_addr, wb_data, fifo_count);
    end

    // Mid-operation reset: fill the buffer behind the ALU, then reset between edges.
    @(negedge clk);
    drive(1, 1, 64'h111, 1, 5, 64'hA5);
    @(negedge clk);
    drive(1, 2, 64'h222, 1, 6, 64'hA6);
    @(posedge clk); #1;
    chk("mid_fill_count", 64'(fifo_count), 64'h2);
    $display("seq fill: count=%0d wb_addr=%0d", fifo_count, wb_addr);
    #2;
    rst_n = 1'b0;
    drive(0, 0, 64'h0, 0, 0, 64'h0);
    #1;
    chk("mid_rst_en",    64'(wb_en),      64'h0);
    chk("mid_rst_addr",  64'(wb_addr),    64'h0);
    chk("mid_rst_data",  wb_data,         64'h0);
    chk("mid_rst_count", 64'(fifo_count), 64'h0);
    chk("mid_rst_ready", 64'(lsu_ready),  64'h1);
    $display("seq async reset: en=%0b count=%0d ready=%0b", wb_en, fifo_count, lsu_ready);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_release_en",    64'(wb_en),      64'h0);
    chk("mid_release_count", 64'(fifo_count), 64'h0);
    // A stale buffered entry would win over the direct path here.
    @(negedge clk);
    drive(0, 0, 64'h0, 1, 10, 64'hAB);
    @(posedge clk); #1;
    chk("after_rst_en",    64'(wb_en),      64'h1);
    chk("after_rst_addr",  64'(wb_addr),    64'd10);
    chk("after_rst_data",  wb_data,         64'hAB);
    chk("after_rst_count", 64'(fifo_count), 64'h0);
    $display("seq post-reset direct: en=%0b addr=%0d data=%0h", wb_en, wb_addr, wb_data);
    @(negedge clk);
    drive(0, 0, 64'h0, 0, 0, 64'h0);

`ifdef WB_FORWARD_EN
    @(negedge clk);
    drive(1, 4, 64'h4444, 0, 0, 64'h0);
    rd_addr_a = 5'd4;
    rd_addr_b = 5'd0;
    @(posedge clk); #1;
    chk("fwd_hit_a",  64'(fwd_hit_a), 64'h1);
    chk("fwd_data_a", fwd_data_a,     64'h4444);
    chk("fwd_hit_b",  64'(fwd_hit_b), 64'h0);
    $display("seq forward: hit_a=%0b data_a=%0h hit_b=%0b", fwd_hit_a, fwd_data_a, fwd_hit_b);
    @(negedge clk);
    drive(0, 0, 64'h0, 0, 0, 64'h0);
    rd_addr_b = 5'd4;
    @(posedge clk); #1;
    chk("fwd_idle_hit_a", 64'(fwd_hit_a), 64'h0);
    chk("fwd_idle_hit_b", 64'(fwd_hit_b), 64'h0);
    $display("seq forward idle: hit_a=%0b hit_b=%0b", fwd_hit_a, fwd_hit_b);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
